truth_table_sequencer: RTL and testbench
========================================

Name: truth_table_sequencer

Overview:
Sequences the lab's two-input boolean datapath through all four input combinations (a,b) = 00,01,10,11 on a single start command. Drives the operands, the live result and an accumulated 4-bit truth table for display on LEDs. Runs a De Morgan / gate-level-XOR self-check on every step. Sits between key/switch inputs and the LED outputs of lab_top, replacing manual key toggling.

Parameters:
step_cycles, 25_000_000, HOLD duration per combination in clk cycles; minimum 1; default is 0.5 s at 50 MHz
w_cnt, $clog2(step_cycles+1), hold counter width (derived)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a run; sampled only in IDLE or DONE
op_sel  input  3  operation: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ~(a&b), 7 ~(a|b)
a_out  output  1  current operand a (= idx[1])
b_out  output  1  current operand b (= idx[0])
result  output  1  op(a_out,b_out) for the current step
table_led  output  4  table_led[idx] = result for combination idx; unvisited bits 0
busy  output  1  high in APPLY or HOLD
done  output  1  high in DONE
check_err  output  1  sticky; set when any self-check fails during a run

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, idx=0, all outputs 0, op latch 0, counter 0. Reset mid-run aborts immediately with no partial hold.
- States: IDLE, APPLY, HOLD, DONE. All outputs registered.
- IDLE/DONE + start=1 at edge T: latch op_sel, idx<=0, table_led<=0, check_err<=0, enter APPLY at T+1. done drops at T+1.
- APPLY (exactly 1 cycle): register a_out=idx[1], b_out=idx[0], result=op(a,b), table_led[idx]=result. Evaluate the self-checks and OR any failure into check_err. Load counter=step_cycles-1. Enter HOLD. Registered values are visible from the cycle after APPLY.
- Self-checks, all required true:
  - ~(a&b) == (~a|~b)
  - ~(a|b) == (~a&~b)
  - (a^b) == ((~a&b)|(a&~b))
- HOLD: lasts step_cycles cycles. When counter==0: if idx==3 go to DONE, else idx<=idx+1 and go to APPLY. Otherwise decrement.
- Step period is step_cycles+1 cycles. The run enters DONE at T+1+4*(step_cycles+1).
- DONE: a_out, b_out, result and table_led hold the last values. done=1 until a new start or rst.
- start while busy: ignored, no restart, no queue.
- op_sel changes during a run are ignored; the value latched at start is used.
- start and rst in the same cycle: rst wins.
- idx is 2 bits and never wraps during a run; the transition from idx 3 always goes to DONE.
- step_cycles=1: HOLD is a single cycle; the counter loads 0.

Test Plan:
- rst held 3 cycles, then released with start=0 -> state IDLE; a_out, b_out, result, table_led, busy, done, check_err all 0 for 20 cycles.
- step_cycles=3, op_sel=0 (AND), start pulse at T -> busy from T+1; table_led reaches 4'b1000; done=1 at T+17; a_out=1, b_out=1, result=1 held.
- step_cycles=3, run op_sel 2, 4, 5, 6 back-to-back from DONE -> table_led 4'b0110, 4'b0001, 4'b1001, 4'b0111; check_err stays 0 throughout.
- op_sel=1 run; at T+6 set op_sel=0 and pulse start -> no restart; final table_led=4'b1110 (OR); done at T+17.
- step_cycles=1, op_sel=3 -> step period 2 cycles; done at T+9; table_led=4'b0111.
- rst asserted at T+9 of a step_cycles=3 run -> next cycle all outputs 0 and IDLE; a new start runs a full clean sequence with correct table_led.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: steps a two-input boolean op through all four (a,b) combinations,
// building a 4-bit truth table and running gate-identity self-checks on every step.
module truth_table_sequencer #(
    parameter int step_cycles = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op_sel,
    output logic       a_out,
    output logic       b_out,
    output logic       result,
    output logic [3:0] table_led,
    output logic       busy,
    output logic       done,
    output logic       check_err
);
    localparam int w_cnt = $clog2(step_cycles + 1);
    typedef enum logic [1:0] {IDLE, APPLY, HOLD, DONE} state_t;
    state_t           r_state, w_next;
    logic [2:0]       r_op;
    logic [1:0]       r_idx;
    logic [w_cnt-1:0] r_cnt;
    logic             w_a, w_b, w_res, w_fail;
    assign w_a = r_idx[1];
    assign w_b = r_idx[0];
    always_comb begin
        w_res = 1'b0;
        case (r_op)
            3'd0: w_res = w_a & w_b;
            3'd1: w_res = w_a | w_b;
            3'd2: w_res = w_a ^ w_b;
            3'd3: w_res = ~(w_a & w_b);
            3'd4: w_res = ~(w_a | w_b);
            3'd5: w_res = ~(w_a ^ w_b);
            3'd6: w_res = ~(w_a & w_b);
            default: w_res = ~(w_a | w_b);
        endcase
    end
    // De Morgan pair plus gate-level XOR; any disagreement flags a broken datapath
    assign w_fail = ((~(w_a & w_b)) != (~w_a | ~w_b))
                  | ((~(w_a | w_b)) != (~w_a & ~w_b))
                  | ((w_a ^ w_b) != ((~w_a & w_b) | (w_a & ~w_b)));
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = start ? APPLY : r_state;
            APPLY:      w_next = HOLD;
            HOLD:       w_next = (r_cnt != '0) ? HOLD : (r_idx == 2'd3) ? DONE : APPLY;
            default:    w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            result    <= 1'b0;
            table_led <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            check_err <= 1'b0;
        end else begin
            busy <= (w_next == APPLY) || (w_next == HOLD);
            done <= (w_next == DONE);
            case (r_state)
                IDLE, DONE: if (start) begin
                    r_op      <= op_sel;
                    r_idx     <= '0;
                    table_led <= '0;
                    check_err <= 1'b0;
                end
                APPLY: begin
                    a_out            <= w_a;
                    b_out            <= w_b;
                    result           <= w_res;
                    table_led[r_idx] <= w_res;
                    check_err        <= check_err | w_fail;
                    r_cnt            <= w_cnt'(step_cycles - 1);
                end
                HOLD: begin
                    if (r_cnt != '0)        r_cnt <= r_cnt - w_cnt'(1);
                    else if (r_idx != 2'd3) r_idx <= r_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: directed plus randomized runs on step_cycles=3 and step_cycles=1 instances.
module tb_truth_table_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start3 = 1'b0, start1 = 1'b0;
    logic [2:0] op3 = '0, op1 = '0;
    logic       a3, b3, r3, busy3, done3, err3;
    logic       a1, b1, r1, busy1, done1, err1;
    logic [3:0] t3, t1;
    int vectors = 0;
    int miscompares = 0;
    always #5 clk = ~clk;
    truth_table_sequencer #(.step_cycles(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .op_sel(op3),
        .a_out(a3), .b_out(b3), .result(r3), .table_led(t3),
        .busy(busy3), .done(done3), .check_err(err3)
    );
    truth_table_sequencer #(.step_cycles(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .op_sel(op1),
        .a_out(a1), .b_out(b1), .result(r1), .table_led(t1),
        .busy(busy1), .done(done1), .check_err(err1)
    );
    function automatic bit ref_bit(input int op, input int a, input int b);
        case (op)
            0: return bit'(a & b);
            1: return bit'(a | b);
            2: return bit'(a != b);
            3, 6: return !(a & b);
            4, 7: return !(a | b);
            default: return bit'(a == b);
        endcase
    endfunction
    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic chk_zero(input bit which);
        chk("zero_a",    which ? a1 : a3, 0);
        chk("zero_b",    which ? b1 : b3, 0);
        chk("zero_res",  which ? r1 : r3, 0);
        chk("zero_tbl",  which ? t1 : t3, 0);
        chk("zero_busy", which ? busy1 : busy3, 0);
        chk("zero_done", which ? done1 : done3, 0);
        chk("zero_err",  which ? err1 : err3, 0);
    endtask
    task automatic set_start(input bit which, input logic s);
        if (which) start1 = s; else start3 = s;
    endtask
    task automatic set_op(input bit which, input int op);
        if (which) op1 = 3'(op); else op3 = 3'(op);
    endtask
    // One run: start edge is n=0 sample point; step period p = step_cycles+1.
    // inject: cycle at which a busy-time start with op 0 is raised; abort: cycle at which rst hits.
    task automatic run(input bit which, input int op, input int inject, input int abort);
        int p, comp, exp_tbl, idx;
        p = which ? 2 : 4;
        @(posedge clk); #1;
        set_op(which, op);
        set_start(which, 1'b1);
        @(posedge clk); #1;
        for (int n = 0; n <= 4 * p + 3; n++) begin
            if (n == abort) begin
                rst = 1'b1;
                set_start(which, 1'b0);
                @(posedge clk); #1;
                rst = 1'b0;
                chk_zero(which);
                chk_zero(!which);
                return;
            end
            set_start(which, n == inject);
            set_op(which, (n == inject) ? 0 : int'($urandom_range(0, 7)));
            comp = 0;
            for (int k = 0; k < 4; k++) if (1 + k * p <= n) comp++;
            exp_tbl = 0;
            for (int i = 0; i < comp; i++) exp_tbl |= int'(ref_bit(op, i / 2, i % 2)) << i;
            chk("table_led", which ? t1 : t3, exp_tbl);
            chk("busy", which ? busy1 : busy3, int'(n < 4 * p));
            chk("done", which ? done1 : done3, int'(n >= 4 * p));
            chk("check_err", which ? err1 : err3, 0);
            if (comp > 0) begin
                idx = comp - 1;
                chk("a_out",  which ? a1 : a3, idx / 2);
                chk("b_out",  which ? b1 : b3, idx % 2);
                chk("result", which ? r1 : r3, int'(ref_bit(op, idx / 2, idx % 2)));
            end
            @(posedge clk); #1;
        end
        set_start(which, 1'b0);
    endtask
    initial begin
        int w, o, inj;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk_zero(1'b0);
            chk_zero(1'b1);
            @(posedge clk); #1;
        end
        run(1'b0, 0, -1, -1);
        run(1'b0, 2, -1, -1);
        run(1'b0, 4, -1, -1);
        run(1'b0, 5, -1, -1);
        run(1'b0, 6, -1, -1);
        run(1'b0, 1, 5, -1);
        run(1'b1, 3, -1, -1);
        run(1'b0, 7, -1, 8);
        run(1'b0, 2, -1, -1);
        for (int r = 0; r < 12; r++) begin
            w   = int'($urandom_range(0, 1));
            o   = int'($urandom_range(0, 7));
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, (w == 1) ? 7 : 15)) : -1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run(w[0], o, inj, -1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
